// File: rtl/neuron_core_pkg.sv
// Shared constants and scheduler state encoding for the 256x256 neuron core.
package neuron_core_pkg;

    localparam int unsigned N_AXONS   = 256;
    localparam int unsigned N_NEURONS = 256;
    localparam int unsigned AXON_W    = $clog2(N_AXONS);
    localparam int unsigned STATE_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_INTEG = 3'd3,
        S_FIRE  = 3'd4,
        S_CAPT  = 3'd5,
        S_DONE  = 3'd6
    } sched_state_t;

endpackage

// File: rtl/neuron_event_fifo.sv
// Synchronous axon event FIFO with occupancy count; a pop frees a slot for a same-cycle push.
module neuron_event_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       wr_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       rd_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/neuron_tick_scheduler.sv
// Replays queued axon events once per tick (row read, wait, integrate), then fires and counts spikes.
module neuron_tick_scheduler #(
    parameter int unsigned N_AXONS    = neuron_core_pkg::N_AXONS,
    parameter int unsigned N_NEURONS  = neuron_core_pkg::N_NEURONS,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned ROW_LAT    = 1
) (
    input  logic                       wb_clk_i,
    input  logic                       wb_rst_i,
    input  logic                       evt_valid_i,
    input  logic [$clog2(N_AXONS)-1:0] evt_axon_i,
    output logic                       evt_ready_o,
    input  logic                       tick_i,
    output logic                       row_rd_o,
    output logic [$clog2(N_AXONS)-1:0] row_axon_o,
    output logic                       integrate_o,
    output logic                       fire_o,
    input  logic [N_NEURONS-1:0]       spikes_i,
    output logic [8:0]                 spike_count_o,
    output logic [$clog2(N_AXONS):0]   events_done_o,
    output logic                       tick_done_o,
    output logic                       busy_o,
    output logic                       tick_overrun_o
);
    import neuron_core_pkg::*;

    localparam int unsigned AW  = $clog2(N_AXONS);
    localparam int unsigned EW  = AW + 1;
    localparam int unsigned CW  = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned LW  = 3;
    localparam int unsigned SCW = 9;

    sched_state_t   state, state_next;
    logic [CW-1:0]  remaining, remaining_c;
    logic [LW-1:0]  lat_cnt, lat_cnt_c;
    logic [EW-1:0]  evt_cnt, evt_cnt_c, events_done_c;
    logic [AW-1:0]  row_axon_c;
    logic [SCW-1:0] spike_count_c;
    logic           tick_pending, tick_pending_c, tick_overrun_c;
    logic           pop_c;
    logic           fifo_full, fifo_empty;
    logic [AW-1:0]  fifo_head;
    logic [CW-1:0]  fifo_count;

    function automatic logic [SCW-1:0] popcount(input logic [N_NEURONS-1:0] v);
        logic [SCW-1:0] c;
        c = '0;
        for (int i = 0; i < N_NEURONS; i++) c = c + SCW'(v[i]);
        return c;
    endfunction

    assign evt_ready_o = !fifo_full;

    neuron_event_fifo #(
        .WIDTH (AW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (wb_clk_i),
        .rst     (wb_rst_i),
        .push    (evt_valid_i && evt_ready_o),
        .wr_data (evt_axon_i),
        .pop     (pop_c),
        .rd_data (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // Next-state logic; the FIFO head is popped on the edge into ISSUE so row_axon_o is valid with row_rd_o.
    always_comb begin
        state_next     = state;
        remaining_c    = remaining;
        lat_cnt_c      = lat_cnt;
        evt_cnt_c      = evt_cnt;
        events_done_c  = events_done_o;
        row_axon_c     = row_axon_o;
        spike_count_c  = spike_count_o;
        tick_pending_c = tick_pending;
        tick_overrun_c = tick_overrun_o;
        pop_c          = 1'b0;

        if (tick_i && state != S_IDLE) begin
            if (tick_pending) tick_overrun_c = 1'b1;
            else              tick_pending_c = 1'b1;
        end

        case (state)
            S_IDLE: begin
                if (tick_i || tick_pending) begin
                    remaining_c    = fifo_count;
                    evt_cnt_c      = '0;
                    tick_pending_c = tick_i && tick_pending;
                    if (!fifo_empty) begin
                        state_next = S_ISSUE;
                        pop_c      = 1'b1;
                        row_axon_c = fifo_head;
                    end else begin
                        state_next = S_FIRE;
                    end
                end
            end
            S_ISSUE: begin
                lat_cnt_c  = LW'(ROW_LAT - 1);
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (lat_cnt == '0) state_next = S_INTEG;
                else               lat_cnt_c  = lat_cnt - LW'(1);
            end
            S_INTEG: begin
                remaining_c = remaining - CW'(1);
                evt_cnt_c   = evt_cnt + EW'(1);
                if (remaining > CW'(1)) begin
                    state_next = S_ISSUE;
                    pop_c      = 1'b1;
                    row_axon_c = fifo_head;
                end else begin
                    state_next = S_FIRE;
                end
            end
            S_FIRE: state_next = S_CAPT;
            S_CAPT: begin
                spike_count_c = popcount(spikes_i);
                events_done_c = evt_cnt;
                state_next    = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Strobes are registered from the next state so each lines up with its state cycle.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state          <= S_IDLE;
            remaining      <= '0;
            lat_cnt        <= '0;
            evt_cnt        <= '0;
            tick_pending   <= 1'b0;
            tick_overrun_o <= 1'b0;
            row_axon_o     <= '0;
            spike_count_o  <= '0;
            events_done_o  <= '0;
            row_rd_o       <= 1'b0;
            integrate_o    <= 1'b0;
            fire_o         <= 1'b0;
            tick_done_o    <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            state          <= state_next;
            remaining      <= remaining_c;
            lat_cnt        <= lat_cnt_c;
            evt_cnt        <= evt_cnt_c;
            tick_pending   <= tick_pending_c;
            tick_overrun_o <= tick_overrun_c;
            row_axon_o     <= row_axon_c;
            spike_count_o  <= spike_count_c;
            events_done_o  <= events_done_c;
            row_rd_o       <= (state_next == S_ISSUE);
            integrate_o    <= (state_next == S_INTEG);
            fire_o         <= (state_next == S_FIRE);
            tick_done_o    <= (state_next == S_DONE);
            busy_o         <= (state_next != S_IDLE);
        end
    end

endmodule

// File: tb/tb_neuron_tick_scheduler.sv
// Directed bench for neuron_tick_scheduler with a row/tick scoreboard; a second instance runs ROW_LAT=4.
module tb_neuron_tick_scheduler;
    import neuron_core_pkg::*;

    localparam int unsigned AW = AXON_W;
    localparam int unsigned NN = N_NEURONS;

    typedef struct {
        int events;
        int spikes;
    } tick_exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    logic          rst;
    logic [NN-1:0] spikes;

    logic          evt_valid, evt_ready, tick, row_rd, integ, fire;
    logic [AW-1:0] evt_axon, row_axon;
    logic [8:0]    spike_count;
    logic [AW:0]   events_done;
    logic          tick_done, busy, overrun;

    logic          evt_valid4, evt_ready4, tick4, row_rd4, integ4, fire4;
    logic [AW-1:0] evt_axon4, row_axon4;
    logic [8:0]    spike_count4;
    logic [AW:0]   events_done4;
    logic          tick_done4, busy4, overrun4;

    logic [AW-1:0] exp_rows [$];
    tick_exp_t     exp_ticks [$];
    tick_exp_t     mon_te;
    int            last_rd_cyc = 0;
    logic [AW-1:0] last_axon = '0;

    neuron_tick_scheduler #(.FIFO_DEPTH(16), .ROW_LAT(1)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .evt_valid_i(evt_valid), .evt_axon_i(evt_axon),
        .evt_ready_o(evt_ready), .tick_i(tick), .row_rd_o(row_rd), .row_axon_o(row_axon),
        .integrate_o(integ), .fire_o(fire), .spikes_i(spikes), .spike_count_o(spike_count),
        .events_done_o(events_done), .tick_done_o(tick_done), .busy_o(busy),
        .tick_overrun_o(overrun)
    );

    neuron_tick_scheduler #(.FIFO_DEPTH(16), .ROW_LAT(4)) dut4 (
        .wb_clk_i(clk), .wb_rst_i(rst), .evt_valid_i(evt_valid4), .evt_axon_i(evt_axon4),
        .evt_ready_o(evt_ready4), .tick_i(tick4), .row_rd_o(row_rd4), .row_axon_o(row_axon4),
        .integrate_o(integ4), .fire_o(fire4), .spikes_i(spikes), .spike_count_o(spike_count4),
        .events_done_o(events_done4), .tick_done_o(tick_done4), .busy_o(busy4),
        .tick_overrun_o(overrun4)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_tick(input int e, input int s);
        tick_exp_t t;
        t.events = e;
        t.spikes = s;
        exp_ticks.push_back(t);
    endtask

    task automatic push_evt(input logic [AW-1:0] a);
        int n = 0;
        evt_valid = 1'b1;
        evt_axon  = a;
        while (evt_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("push_ready", 64'(evt_ready), 64'd1);
        exp_rows.push_back(a);
        @(negedge clk);
        evt_valid = 1'b0;
    endtask

    // Waits for tick_done, counting fire pulses on the way; returns one cycle past DONE.
    task automatic wait_done(input string tag, output int at, output int nf);
        int n = 0;
        nf = 0;
        while (n < 300) begin
            if (fire === 1'b1) nf++;
            if (tick_done === 1'b1) break;
            @(negedge clk);
            n++;
        end
        check({tag, "_done_seen"}, 64'(tick_done), 64'd1);
        at = cyc;
        @(negedge clk);
    endtask

    // Scoreboard for the ROW_LAT=1 instance.
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            check("strobe_mutex", 64'((32'(row_rd) + 32'(integ) + 32'(fire)) <= 32'd1), 64'd1);
            if (row_rd === 1'b1) begin
                check("row_expected", 64'(exp_rows.size() > 0), 64'd1);
                if (exp_rows.size() > 0) check("row_axon", 64'(row_axon), 64'(exp_rows.pop_front()));
                last_rd_cyc = cyc;
                last_axon   = row_axon;
            end
            if (integ === 1'b1) begin
                check("integ_gap", 64'(cyc - last_rd_cyc), 64'd2);
                check("integ_axon", 64'(row_axon), 64'(last_axon));
            end
            if (tick_done === 1'b1) begin
                check("tick_expected", 64'(exp_ticks.size() > 0), 64'd1);
                if (exp_ticks.size() > 0) begin
                    mon_te = exp_ticks.pop_front();
                    check("events_done", 64'(events_done), 64'(mon_te.events));
                    check("spike_count", 64'(spike_count), 64'(mon_te.spikes));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, td, td2, nf, n, rd_c, n_integ, n_rows4;
        logic [AW-1:0] a4;
        logic [AW-1:0] exp4 [$];
        logic in_flight4;

        rst = 1'b1; spikes = '0;
        evt_valid = 1'b0; evt_axon = '0; tick = 1'b0;
        evt_valid4 = 1'b0; evt_axon4 = '0; tick4 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        check("rst_ready", 64'(evt_ready), 64'd1);
        check("rst_strobes", 64'({row_rd, integ, fire, tick_done, busy}), 64'd0);
        check("rst_spike_count", 64'(spike_count), 64'd0);
        check("rst_events_done", 64'(events_done), 64'd0);
        check("rst_overrun", 64'(overrun), 64'd0);

        // Three events, ROW_LAT=1.
        spikes = '0; spikes[0] = 1'b1; spikes[100] = 1'b1; spikes[255] = 1'b1;
        push_evt(AW'(3)); push_evt(AW'(200)); push_evt(AW'(255));
        expect_tick(3, 3);
        t0 = cyc; tick = 1'b1; @(negedge clk); tick = 1'b0;
        check("t1_busy_rise", 64'(busy), 64'd1);
        wait_done("t1", td, nf);
        check("t1_latency", 64'(td - t0), 64'd12);
        check("t1_fire_count", 64'(nf), 64'd1);

        // Empty tick with every neuron spiking.
        spikes = '1;
        expect_tick(0, 256);
        t0 = cyc; tick = 1'b1; @(negedge clk); tick = 1'b0;
        check("t2_fire_next", 64'(fire), 64'd1);
        wait_done("t2", td, nf);
        check("t2_latency", 64'(td - t0), 64'd3);
        check("t2_fire_count", 64'(nf), 64'd1);

        // Full FIFO with a 17th event held valid across the tick.
        spikes = {8{32'h0000_FFFF}};
        for (int i = 0; i < 16; i++) push_evt(AW'(i * 16 + 3));
        check("t3_full_not_ready", 64'(evt_ready), 64'd0);
        evt_valid = 1'b1; evt_axon = AW'(99);
        expect_tick(16, 128);
        t0 = cyc; tick = 1'b1; @(negedge clk); tick = 1'b0;
        check("t3_ready_after_pop", 64'(evt_ready), 64'd1);
        exp_rows.push_back(AW'(99));
        @(negedge clk); evt_valid = 1'b0;
        wait_done("t3a", td, nf);
        check("t3a_latency", 64'(td - t0), 64'd51);
        expect_tick(1, 128);
        t0 = cyc; tick = 1'b1; @(negedge clk); tick = 1'b0;
        wait_done("t3b", td, nf);
        check("t3b_latency", 64'(td - t0), 64'd6);

        // Same-cycle push excluded from snapshot, pending tick, overrun.
        push_evt(AW'(10)); push_evt(AW'(20));
        expect_tick(2, 128);
        expect_tick(1, 128);
        evt_valid = 1'b1; evt_axon = AW'(30); exp_rows.push_back(AW'(30));
        t0 = cyc; tick = 1'b1; @(negedge clk); tick = 1'b0; evt_valid = 1'b0;
        n = 0;
        while (integ !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        check("p_integ_cycle", 64'(cyc - t0), 64'd3);
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        @(negedge clk);
        check("p_no_overrun_yet", 64'(overrun), 64'd0);
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        wait_done("p1", td, nf);
        check("p1_latency", 64'(td - t0), 64'd9);
        check("p_busy_gap", 64'(busy), 64'd0);
        check("p_overrun", 64'(overrun), 64'd1);
        wait_done("p2", td2, nf);
        check("p2_after_p1", 64'(td2 - td), 64'd7);

        // ROW_LAT=4 instance: ROW_LAT wait cycles between row_rd_o and integrate_o.
        exp4.push_back(AW'(5)); exp4.push_back(AW'(250));
        check("l4_ready", 64'(evt_ready4), 64'd1);
        for (int i = 0; i < 2; i++) begin
            evt_valid4 = 1'b1; evt_axon4 = exp4[i]; @(negedge clk);
        end
        evt_valid4 = 1'b0;
        t0 = cyc; tick4 = 1'b1; @(negedge clk); tick4 = 1'b0;
        n = 0; rd_c = 0; a4 = '0; in_flight4 = 1'b0; n_rows4 = 0;
        while (tick_done4 !== 1'b1 && n < 100) begin
            check("l4_mutex", 64'((32'(row_rd4) + 32'(integ4) + 32'(fire4)) <= 32'd1), 64'd1);
            if (row_rd4 === 1'b1) begin
                n_rows4++;
                if (exp4.size() > 0) check("l4_row_axon", 64'(row_axon4), 64'(exp4.pop_front()));
                rd_c = cyc; a4 = row_axon4; in_flight4 = 1'b1;
            end else if (in_flight4) begin
                check("l4_axon_stable", 64'(row_axon4), 64'(a4));
                if (integ4 === 1'b1) begin
                    check("l4_integ_gap", 64'(cyc - rd_c), 64'd5);
                    in_flight4 = 1'b0;
                end
            end
            @(negedge clk);
            n++;
        end
        check("l4_done_seen", 64'(tick_done4), 64'd1);
        check("l4_latency", 64'(cyc - t0), 64'd15);
        check("l4_rows", 64'(n_rows4), 64'd2);
        check("l4_events_done", 64'(events_done4), 64'd2);

        // Reset while waiting for row data aborts the tick and empties the FIFO.
        push_evt(AW'(40)); push_evt(AW'(41));
        tick = 1'b1; @(negedge clk); tick = 1'b0;
        check("r_row_rd", 64'(row_rd), 64'd1);
        @(negedge clk);
        rst = 1'b1; @(negedge clk); rst = 1'b0;
        exp_rows.delete();
        check("r_ready", 64'(evt_ready), 64'd1);
        check("r_busy", 64'(busy), 64'd0);
        check("r_overrun_cleared", 64'(overrun), 64'd0);
        n_integ = 0;
        repeat (8) begin
            if (integ === 1'b1) n_integ++;
            @(negedge clk);
        end
        check("r_no_integ", 64'(n_integ), 64'd0);
        spikes = '1;
        expect_tick(0, 256);
        t0 = cyc; tick = 1'b1; @(negedge clk); tick = 1'b0;
        wait_done("r_empty", td, nf);
        check("r_empty_latency", 64'(td - t0), 64'd3);

        repeat (3) @(negedge clk);
        check("sb_rows_drained", 64'(exp_rows.size()), 64'd0);
        check("sb_ticks_drained", 64'(exp_ticks.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
